// File: rtl/sincronize_pkg.sv
// rtl/sincronize_pkg.sv - shared constants and edge-select helper for the key synchroniser
//
// Purpose : edge-select encodings, default build parameters and the
//           function that maps (rise, fall, select) to a detect pulse.
// Ports   : none (package).
package sincronize_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // Any unrecognised select falls back to rising-edge detection.
  function automatic logic edge_hit(input logic rise, input logic fall, input int sel);
    case (sel)
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return rise;
    endcase
  endfunction

endpackage

// File: rtl/sincronize_sync_chain.sv
// rtl/sincronize_sync_chain.sv - metastability shift chain with asynchronous clear
//
// Purpose : moves an asynchronous level into the clk domain through STAGES flops.
// Ports   : clk - clock; rst - async active-high clear;
//           d   - asynchronous input level; q - synchronised level (last stage).
module sincronize_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/sincronize.sv
// rtl/sincronize.sv - key level synchroniser with registered one-shot edge pulse
//
// Purpose : synchronises key_press into clk, optionally debounces it
//           (build macro KEY_DEBOUNCE_EN), and emits a one-cycle registered
//           key_detect pulse on the edge chosen by EDGE_SEL.
// Ports   : clk        - system clock, rising edge
//           rst        - asynchronous active-high reset
//           key_press  - raw asynchronous key level, high = pressed
//           key_detect - registered one-cycle pulse per accepted edge
module sincronize
  import sincronize_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int EDGE_SEL        = EDGE_RISE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_press,
  output logic key_detect
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 ||
      EDGE_SEL < EDGE_RISE || EDGE_SEL > EDGE_BOTH) begin : g_bad_param
    $error("sincronize: parameter out of range");
  end

  logic lvl;      // synchronised raw level
  logic det_lvl;  // level the edge detector watches
  logic prev;
  logic rise;
  logic fall;

  sincronize_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (key_press),
    .q  (lvl)
  );

`ifdef KEY_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] db_cnt;
  logic             clean;

  // The count is the number of consecutive samples lvl has disagreed with
  // clean; the sample that would bring it to DEBOUNCE_CYCLES commits lvl.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      clean  <= 1'b0;
    end else if (lvl == clean) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      clean  <= lvl;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign det_lvl = clean;
`else
  assign det_lvl = lvl;
`endif

  always_comb begin
    rise = det_lvl & ~prev;
    fall = ~det_lvl & prev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= 1'b0;
      key_detect <= 1'b0;
    end else begin
      prev       <= det_lvl;
      key_detect <= edge_hit(rise, fall, EDGE_SEL);
    end
  end

endmodule

// File: tb/tb_sincronize.sv
// tb/tb_sincronize.sv - directed self-checking bench for sincronize
module tb_sincronize;
  import sincronize_pkg::*;

  localparam int SS = DEF_SYNC_STAGES;
  localparam int DB = DEF_DEBOUNCE_CYCLES;
`ifdef KEY_DEBOUNCE_EN
  localparam int LAT   = SS + DB;
  localparam int PRESS = DB + 2;
`else
  localparam int LAT   = SS;
  localparam int PRESS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_press = 1'b0;
  logic [2:0] kd;

  sincronize #(.SYNC_STAGES(SS), .EDGE_SEL(EDGE_RISE), .DEBOUNCE_CYCLES(DB)) u_rise (
    .clk(clk), .rst(rst), .key_press(key_press), .key_detect(kd[0]));
  sincronize #(.SYNC_STAGES(SS), .EDGE_SEL(EDGE_FALL), .DEBOUNCE_CYCLES(DB)) u_fall (
    .clk(clk), .rst(rst), .key_press(key_press), .key_detect(kd[1]));
  sincronize #(.SYNC_STAGES(SS), .EDGE_SEL(EDGE_BOTH), .DEBOUNCE_CYCLES(DB)) u_both (
    .clk(clk), .rst(rst), .key_press(key_press), .key_detect(kd[2]));

  always #10 clk = ~clk;

  // Monitor on the falling edge: cycle index, pulse starts, high samples.
  int         cyc = 0;
  int         pulses[3] = '{0, 0, 0};
  int         highs[3] = '{0, 0, 0};
  int         last_rise[3] = '{-1, -1, -1};
  logic [2:0] kd_q = 3'b000;

  always @(negedge clk) begin
    cyc  <= cyc + 1;
    kd_q <= kd;
    for (int i = 0; i < 3; i++) begin
      if (kd[i]) highs[i] <= highs[i] + 1;
      if (kd[i] && !kd_q[i]) begin
        pulses[i]    <= pulses[i] + 1;
        last_rise[i] <= cyc + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int p0[3];
  int h0[3];
  int base;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    p0 = pulses;
    h0 = highs;
  endtask

  // Called at negedge+1; key high for len samples; base = reference cycle.
  task automatic press(input int len, output int b);
    b = cyc;
    key_press = 1'b1;
    wait_neg(len);
    key_press = 1'b0;
  endtask

  initial begin
    // Reset hold while the key toggles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("rst_hold_kd", int'(kd), 0);
      key_press = ~key_press;
    end
    key_press = 1'b0;
    rst = 1'b0;
    wait_neg(5);
    check("reset_state_kd", int'(kd), 0);
    check("reset_state_pulses", pulses[0] + pulses[1] + pulses[2], 0);

`ifndef KEY_DEBOUNCE_EN
    // One-sample press.
    snap();
    press(1, base);
    wait_neg(10);
    check("single_pulses", pulses[0] - p0[0], 1);
    check("single_width", highs[0] - h0[0], 1);
    check("single_latency", last_rise[0], base + 1 + SS);

    // 30/40/50 ns presses with equal low times.
    snap();
    key_press = 1'b1; #30; key_press = 1'b0; #30;
    key_press = 1'b1; #40; key_press = 1'b0; #40;
    key_press = 1'b1; #50; key_press = 1'b0; #50;
    wait_neg(10);
    check("multi_pulses", pulses[0] - p0[0], 3);
    check("multi_width", highs[0] - h0[0], 3);
`else
    // Too-short press is rejected.
    snap();
    press(2, base);
    wait_neg(20);
    check("db_short_pulses", pulses[0] - p0[0], 0);
    // Six-sample press is accepted after six edges.
    snap();
    press(6, base);
    wait_neg(20);
    check("db_long_pulses", pulses[0] - p0[0], 1);
    check("db_long_latency", last_rise[0], base + 1 + 6);
`endif

    // Long hold: one rise pulse, fall after release, both gives two.
    snap();
    press(10, base);
    wait_neg(10 + LAT);
    check("hold_rise_pulses", pulses[0] - p0[0], 1);
    check("hold_rise_width", highs[0] - h0[0], 1);
    check("hold_rise_latency", last_rise[0], base + 1 + LAT);
    check("hold_fall_pulses", pulses[1] - p0[1], 1);
    check("hold_fall_latency", last_rise[1], base + 1 + 10 + LAT);
    check("hold_both_pulses", pulses[2] - p0[2], 2);
    check("hold_both_width", highs[2] - h0[2], 2);

    // Reset during a pulse, key held across release.
    base = cyc;
    key_press = 1'b1;
    wait_neg(1 + LAT);
    check("midrst_pulse_present", int'(kd[0]), 1);
    rst = 1'b1;
    #1;
    check("midrst_pulse_killed", int'(kd), 0);
    wait_neg(1);
    rst = 1'b0;
    base = cyc;
    snap();
    wait_neg(LAT + 8);
    check("midrst_after_pulses", pulses[0] - p0[0], 1);
    check("midrst_after_latency", last_rise[0], base + LAT + 1);
    key_press = 1'b0;
    wait_neg(LAT + 8);

    // Normal press afterwards.
    snap();
    press(PRESS, base);
    wait_neg(LAT + 10);
    check("post_pulses", pulses[0] - p0[0], 1);
    check("post_latency", last_rise[0], base + 1 + LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
